// File: rtl/sat_sum_pipe.sv
// Two-stage fixed-point saturating adder/accumulator: S1 aligns both operands to the
// output format, S2 sums, narrows (saturate or wrap) and keeps sticky saturation stats.
module sat_sum_pipe #(
  parameter int IN1_W  = 22,
  parameter int IN1_FL = 14,
  parameter int IN2_W  = 39,
  parameter int IN2_FL = 28,
  parameter int OUT_W  = 36,
  parameter int OUT_FL = 27,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_enable,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             acc_clr,
  input  logic             cnt_clr,
  input  logic [IN1_W-1:0] In1,
  input  logic [IN2_W-1:0] In2,
  output logic [OUT_W-1:0] Out1,
  output logic             out_valid,
  output logic             sat_flag,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] sat_count
);

  localparam int D1 = IN1_FL - OUT_FL;
  localparam int R1 = (D1 > 0) ? D1 : 0;
  localparam int L1 = (D1 < 0) ? -D1 : 0;
  localparam int A1 = (D1 > 0) ? IN1_W + 1 : IN1_W + L1;
  localparam int B1 = (R1 == 0) ? 0 : ((R1 - 1 < IN1_W) ? R1 - 1 : IN1_W - 1);

  localparam int D2 = IN2_FL - OUT_FL;
  localparam int R2 = (D2 > 0) ? D2 : 0;
  localparam int L2 = (D2 < 0) ? -D2 : 0;
  localparam int A2 = (D2 > 0) ? IN2_W + 1 : IN2_W + L2;
  localparam int B2 = (R2 == 0) ? 0 : ((R2 - 1 < IN2_W) ? R2 - 1 : IN2_W - 1);

  // Sum must also hold the OUT_W-wide accumulator feedback plus one carry bit.
  localparam int AM = (A1 > A2) ? A1 : A2;
  localparam int SW = ((AM > OUT_W) ? AM : OUT_W) + 1;

  logic signed [A1-1:0] ext1, al1;
  logic signed [A2-1:0] ext2, al2;
  logic                 rnd1, rnd2;

  // Round half-up: after the arithmetic shift, add back the last bit shifted out.
  always_comb begin
    ext1 = A1'($signed(In1));
    ext2 = A2'($signed(In2));
    rnd1 = (R1 > 0) ? In1[B1] : 1'b0;
    rnd2 = (R2 > 0) ? In2[B2] : 1'b0;
    al1  = ((ext1 <<< L1) >>> R1) + $signed({{(A1-1){1'b0}}, rnd1});
    al2  = ((ext2 <<< L2) >>> R2) + $signed({{(A2-1){1'b0}}, rnd2});
  end

  logic                 s1_valid_q, s1_mode_q, s1_clr_q;
  logic signed [A1-1:0] s1_a1_q;
  logic signed [A2-1:0] s1_a2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_a1_q    <= '0;
      s1_a2_q    <= '0;
    end else if (clk_enable) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode;
        s1_clr_q  <= acc_clr;
        s1_a1_q   <= al1;
        s1_a2_q   <= al2;
      end
    end
  end

  logic [OUT_W-1:0]    out1_q;
  logic                out_valid_q, sat_flag_q, sat_sticky_q;
  logic [CNT_W-1:0]    sat_count_q;
  logic signed [SW-1:0] x1, x2, xacc, sum;
  logic [SW-OUT_W:0]   sum_hi;
  logic                ovf;
  logic [OUT_W-1:0]    narrowed;

  always_comb begin
    x1   = SW'(s1_a1_q);
    x2   = SW'(s1_a2_q);
    xacc = SW'($signed(out1_q));
    if (!s1_mode_q) begin
      sum = x1 + x2;
    end else if (s1_clr_q) begin
      sum = x1;
    end else begin
      sum = xacc + x1;
    end
    // Fits OUT_W only if every bit from the output sign position upward agrees.
    sum_hi = sum[SW-1:OUT_W-1];
    ovf    = !((&sum_hi) || !(|sum_hi));
    if (ovf && (SAT_EN != 0)) begin
      narrowed = sum[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      narrowed = sum[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out1_q       <= '0;
      out_valid_q  <= 1'b0;
      sat_flag_q   <= 1'b0;
      sat_sticky_q <= 1'b0;
      sat_count_q  <= '0;
    end else if (clk_enable) begin
      out_valid_q <= s1_valid_q;
      sat_flag_q  <= s1_valid_q & ovf;
      if (s1_valid_q) begin
        out1_q <= narrowed;
      end
      if (cnt_clr) begin
        sat_count_q  <= '0;
        sat_sticky_q <= 1'b0;
      end else if (s1_valid_q && ovf) begin
        sat_sticky_q <= 1'b1;
        if (!(&sat_count_q)) begin
          sat_count_q <= sat_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign Out1       = out1_q;
  assign out_valid  = out_valid_q;
  assign sat_flag   = sat_flag_q;
  assign sat_sticky = sat_sticky_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_sat_sum_pipe.sv
// Bench for sat_sum_pipe: three instances (saturating, wrapping, 2-bit counter) share
// one stimulus stream and are compared every cycle against an arithmetic reference model.
module tb_sat_sum_pipe;

  localparam int IN1_FL = 14;
  localparam int IN2_FL = 28;
  localparam int OUT_W  = 36;
  localparam int OUT_FL = 27;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_enable = 1'b1;
  logic        in_valid = 1'b0;
  logic        mode = 1'b0;
  logic        acc_clr = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [21:0] in1 = '0;
  logic [38:0] in2 = '0;

  logic [35:0] out1 [3];
  logic        out_valid [3];
  logic        sat_flag [3];
  logic        sat_sticky [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  sat_sum_pipe #(.SAT_EN(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .in_valid(in_valid),
    .mode(mode), .acc_clr(acc_clr), .cnt_clr(cnt_clr), .In1(in1), .In2(in2),
    .Out1(out1[0]), .out_valid(out_valid[0]), .sat_flag(sat_flag[0]),
    .sat_sticky(sat_sticky[0]), .sat_count(cnt0)
  );

  sat_sum_pipe #(.SAT_EN(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .in_valid(in_valid),
    .mode(mode), .acc_clr(acc_clr), .cnt_clr(cnt_clr), .In1(in1), .In2(in2),
    .Out1(out1[1]), .out_valid(out_valid[1]), .sat_flag(sat_flag[1]),
    .sat_sticky(sat_sticky[1]), .sat_count(cnt1)
  );

  sat_sum_pipe #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .in_valid(in_valid),
    .mode(mode), .acc_clr(acc_clr), .cnt_clr(cnt_clr), .In1(in1), .In2(in2),
    .Out1(out1[2]), .out_valid(out_valid[2]), .sat_flag(sat_flag[2]),
    .sat_sticky(sat_sticky[2]), .sat_count(cnt2)
  );

  typedef struct {
    longint due;
    longint a;
    longint b;
    bit     m;
    bit     c;
  } txn_t;

  txn_t   pend[$];
  longint ecyc;
  longint e_out [3];
  longint e_cnt [3];
  bit     e_flag [3];
  bit     e_sticky [3];
  bit     e_valid;
  longint cmax [3] = '{65535, 65535, 3};
  bit     sat_m [3] = '{1'b1, 1'b0, 1'b1};

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sx36(input logic [35:0] v);
    return longint'($signed(v));
  endfunction

  // Value in output LSBs: x * 2^(OUT_FL-fl), rounded half toward +inf.
  function automatic longint align(input longint x, input int fl);
    int     d;
    longint one;
    d   = fl - OUT_FL;
    one = 1;
    if (d > 0) return (x + (one <<< (d - 1))) >>> d;
    if (d < 0) return x * (one <<< (-d));
    return x;
  endfunction

  function automatic void narrow(input longint s, input bit sat, output longint r,
                                 output bit f);
    longint one, hi, lo, span;
    one  = 1;
    span = one <<< OUT_W;
    hi   = (one <<< (OUT_W - 1)) - 1;
    lo   = -(one <<< (OUT_W - 1));
    if (sat) begin
      r = (s > hi) ? hi : ((s < lo) ? lo : s);
    end else begin
      r = s % span;
      if (r < 0) r += span;
      if (r > hi) r -= span;
    end
    f = (r != s);
  endfunction

  task automatic model_reset();
    pend.delete();
    e_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e_out[i] = 0; e_cnt[i] = 0; e_flag[i] = 1'b0; e_sticky[i] = 1'b0;
    end
  endtask

  // One enabled clock edge: retire the transaction due now, then accept the input.
  task automatic model_edge();
    bit     has;
    longint s, r;
    bit     f;
    txn_t   t;
    ecyc++;
    has = (pend.size() > 0) && (pend[0].due == ecyc);
    e_valid = has;
    for (int i = 0; i < 3; i++) begin
      f = 1'b0;
      if (has) begin
        t = pend[0];
        if (!t.m) s = align(t.a, IN1_FL) + align(t.b, IN2_FL);
        else if (t.c) s = align(t.a, IN1_FL);
        else s = e_out[i] + align(t.a, IN1_FL);
        narrow(s, sat_m[i], r, f);
        e_out[i] = r;
      end
      e_flag[i] = f;
      if (cnt_clr) begin
        e_cnt[i] = 0; e_sticky[i] = 1'b0;
      end else if (f) begin
        e_sticky[i] = 1'b1;
        if (e_cnt[i] < cmax[i]) e_cnt[i]++;
      end
    end
    if (has) void'(pend.pop_front());
    if (in_valid)
      pend.push_back('{ecyc + 1, longint'($signed(in1)), longint'($signed(in2)), mode, acc_clr});
  endtask

  task automatic check_all();
    longint gc [3];
    gc[0] = longint'(cnt0);
    gc[1] = longint'(cnt1);
    gc[2] = longint'(cnt2);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("out1[%0d]", i), sx36(out1[i]), e_out[i]);
      check($sformatf("out_valid[%0d]", i), longint'(out_valid[i]), longint'(e_valid));
      check($sformatf("sat_flag[%0d]", i), longint'(sat_flag[i]), longint'(e_flag[i]));
      check($sformatf("sat_sticky[%0d]", i), longint'(sat_sticky[i]), longint'(e_sticky[i]));
      check($sformatf("sat_count[%0d]", i), gc[i], e_cnt[i]);
    end
  endtask

  task automatic step(input bit v, input bit m, input bit c, input longint a,
                      input longint b, input bit en, input bit cc);
    in_valid   = v;
    mode       = m;
    acc_clr    = c;
    in1        = a[21:0];
    in2        = b[38:0];
    clk_enable = en;
    cnt_clr    = cc;
    @(posedge clk);
    if (en) model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  localparam longint P1MAX = 64'sh1F_FFFF;
  localparam longint P2MAX = 64'sh3F_FFFF_FFFF;
  localparam longint ACC100 = 64'sd13421772800;

  logic [21:0] r1;
  logic [38:0] r2;

  initial begin
    ecyc = 0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Basic add: 1.0 + 0.5
    step(1, 0, 0, 16384, 134217728, 1, 0);
    idle(1);
    check("basic_add", sx36(out1[0]), 201326592);
    check("basic_valid", longint'(out_valid[0]), 1);

    // Rounding of In2 (one fraction bit dropped)
    step(1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, -1, 1, 0);
    check("round_p1", sx36(out1[0]), 1);
    step(1, 0, 0, 0, -3, 1, 0);
    check("round_m1", sx36(out1[0]), 0);
    idle(1);
    check("round_m3", sx36(out1[0]), -1);

    // Positive and negative saturation
    step(1, 0, 0, P1MAX, P2MAX, 1, 0);
    step(1, 0, 0, -P1MAX - 1, -P2MAX - 1, 1, 0);
    check("sat_pos", sx36(out1[0]), 64'sh7_FFFF_FFFF);
    check("sat_pos_flag", longint'(sat_flag[0]), 1);
    check("sat_pos_cnt", longint'(cnt0), 1);
    check("wrap_flag", longint'(sat_flag[1]), 1);
    idle(1);
    check("sat_neg", sx36(out1[0]), -64'sh8_0000_0000);

    // Accumulate 100.0 three times, then restart
    step(1, 1, 1, 1638400, 0, 1, 0);
    step(1, 1, 0, 1638400, 0, 1, 0);
    check("acc_100", sx36(out1[0]), ACC100);
    step(1, 1, 0, 1638400, 0, 1, 0);
    check("acc_200", sx36(out1[0]), 2 * ACC100);
    step(1, 1, 1, 1638400, 0, 1, 0);
    check("acc_sat", sx36(out1[0]), 64'sh7_FFFF_FFFF);
    check("acc_sat_flag", longint'(sat_flag[0]), 1);
    idle(1);
    check("acc_restart", sx36(out1[0]), ACC100);

    // Stall mid-stream, with a bubble inside the accumulation
    step(1, 1, 1, 5000, 0, 1, 0);
    step(1, 1, 0, -700, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 12345, 999, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 33, 0, 1, 0);
    idle(2);

    // Reset with samples in flight
    step(1, 0, 0, 777, 888, 1, 0);
    in_valid = 1'b1;
    in1 = 22'd99;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_out1", sx36(out1[0]), 0);
    check("rst_count", longint'(cnt0), 0);
    check_all();
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(3);

    // 2-bit counter saturates at 3; clear wins over a coincident event
    step(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, P1MAX, P2MAX, 1, 0);
    idle(2);
    check("cnt2_hold", longint'(cnt2), 3);
    step(1, 0, 0, P1MAX, P2MAX, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    check("clr_flag", longint'(sat_flag[2]), 1);
    check("clr_cnt", longint'(cnt2), 0);
    check("clr_sticky", longint'(sat_sticky[2]), 0);

    // Randomised mixed traffic
    for (int n = 0; n < 1500; n++) begin
      r1 = 22'($urandom);
      r2 = 39'({$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) r1 = 22'($signed(r1) >>> $urandom_range(0, 20));
      if ($urandom_range(0, 2) == 0) r2 = 39'($signed(r2) >>> $urandom_range(0, 37));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 4) == 0), longint'($signed(r1)), longint'($signed(r2)),
           1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 29) == 0));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sat_sum_pipe.md
# sat_sum_pipe

Parametrised, pipelined fixed-point saturating adder and accumulator for the IIR filter datapath. It generalises the per-node combinational sum blocks into one configurable block. The block aligns two signed operands of arbitrary width and binary point to a common output format, rounds half-up, and saturates or wraps. It adds a valid pipeline, clock-enable stall, an accumulate mode and sticky saturation statistics, and serves as the registered sum node between coefficient multipliers and state registers.

## Interface
- IN1_W, 22, In1 word length (sfix, ≥2)
- IN1_FL, 14, In1 fraction length
- IN2_W, 39, In2 word length (≥2)
- IN2_FL, 28, In2 fraction length
- OUT_W, 36, Out1 word length (≥2)
- OUT_FL, 27, Out1 fraction length
- SAT_EN, 1, 1 = saturate on overflow; 0 = two's-complement wrap
- CNT_W, 16, saturation event counter width

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- clk_enable  in  1  global stall; 0 freezes every register, counter and flag
- in_valid  in  1  operand qualifier
- mode  in  1  0 = Out1 = In1+In2; 1 = accumulate Out1 = acc+In1, In2 ignored
- acc_clr  in  1  with in_valid in mode 1: accumulator restarts from In1 alone
- cnt_clr  in  1  synchronous clear of sat_count and sat_sticky
- In1  in  IN1_W  signed operand
- In2  in  IN2_W  signed operand
- Out1  out  OUT_W  registered result
- out_valid  out  1  Out1 qualifier
- sat_flag  out  1  this result saturated/wrapped; aligned to out_valid
- sat_sticky  out  1  set on any sat_flag until cnt_clr
- sat_count  out  CNT_W  saturation events, saturates at all-ones

## Operation
- Alignment per operand to OUT_FL, with d = IN_FL − OUT_FL:
  - d > 0: arithmetic right shift by d, then add bit (d−1) of the original value. This is round-half-up, ties toward +inf.
  - d < 0: left shift by −d, zero-filled.
  - d = 0: pass through.
- Alignment is done in an intermediate wide enough that the rounding carry and shifted integer bits never wrap. Overflow is detected only at the final narrowing.
- Sum is formed at max(aligned widths)+1 bits, then narrowed to OUT_W:
  - SAT_EN=1: above 2^(OUT_W−1)−1 clamps to 0x7F..F; below −2^(OUT_W−1) clamps to 0x80..0.
  - SAT_EN=0: keep low OUT_W bits.
  - sat_flag=1 whenever the narrowed value differs from the exact sum, in either mode.
- Mode 0: Out1 = narrow(a1+a2).
- Mode 1: acc = narrow(acc_prev + a1), where acc_prev is the current Out1 register. With acc_clr=1, acc = narrow(a1). The accumulator is the Out1 register itself, so it holds its saturated value.
- mode and acc_clr are sampled with in_valid and travel with the operands through the pipeline. Mixed-mode streams are legal.
- sat_count increments by 1 for each out_valid & sat_flag and holds at 2^CNT_W−1.
- cnt_clr has priority over a same-cycle increment: count becomes 0 and sticky becomes 0.
- Stage 1 (S1) registers the aligned operands plus valid, mode and acc_clr. Stage 2 (S2) registers the sum/narrow into Out1 along with out_valid and sat_flag.

## Timing
- Latency is 2 enabled cycles from in_valid to out_valid. Throughput is 1 sample per enabled cycle, with no backpressure.
- Reset values (asynchronous, immediate on reset_n=0): Out1=0, out_valid=0, sat_flag=0, sat_sticky=0, sat_count=0, all S1 registers 0.
- Reset mid-stream discards in-flight samples. The first out_valid after release is for the first input accepted after release, two cycles later.
- clk_enable=0 holds every output and internal register, including the counter and a pending cnt_clr effect.
- Out1 holds its last value when out_valid=0. A bubble between valid samples does not disturb the accumulator. sat_flag is 0 on non-valid cycles.
- Back-to-back accumulate samples use the S2 feedback directly, with no hazard and no stall.

## Test plan
Default parameters apply unless a scenario states otherwise.

1. Basic add: In1=16384 (1.0), In2=134217728 (0.5), mode 0 → two cycles later Out1=201326592, out_valid=1, sat_flag=0.
2. Rounding on In2 (d=1):
   - In2=1, In1=0 → Out1=1.
   - In2=−1 → Out1=0.
   - In2=−3 → Out1=−1.
3. Saturation:
   - In2=0x3F_FFFF_FFFF, In1=0x1FFFFF → Out1=0x7_FFFF_FFFF, sat_flag=1, sat_count=1, sat_sticky=1.
   - Negative extremes → Out1=0x8_0000_0000.
   - Rerun with SAT_EN=0 → wrapped low bits, sat_flag=1.
4. Accumulate:
   - mode=1, In1=1638400 (100.0) on 3 consecutive cycles, first with acc_clr=1 → Out1 = 100·2^27, then 200·2^27, then 0x7_FFFF_FFFF with sat_flag=1.
   - Next sample with acc_clr=1 → restarts at 100·2^27.
5. Stall and reset:
   - Drop clk_enable for 3 cycles mid-stream → output sequence is identical, only delayed.
   - Assert reset_n=0 with 2 samples in flight → all outputs 0 immediately, and neither sample ever appears.
6. Counter:
   - CNT_W=2, 5 saturating samples → sat_count=3 and held.
   - cnt_clr coincident with a saturating sample → sat_count=0, sat_sticky=0.
